// File: rtl/csa_final_adder.sv
// Resolves a carry-save (sum, carry) pair into binary, CHUNK bits per clock.
// Valid/ready on both sides; one pair in flight at a time.
module csa_final_adder #(
  parameter int WIDTH = 50,
  parameter int CHUNK = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH:0]   in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH+1:0] out_result,
  output logic             busy
);

  localparam int NCHUNK = (WIDTH + 2 + CHUNK - 1) / CHUNK;
  localparam int P      = NCHUNK * CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [P-1:0]     a_q, a_d;
  logic [P-1:0]     b_q, b_d;
  logic [WIDTH+1:0] r_q, r_d;
  logic [KW-1:0]    k_q, k_d;
  logic             c_q, c_d;
  logic [CHUNK:0]   csum;
  logic [31:0]      base;

  assign base = 32'(k_q) * 32'(CHUNK);

  // One chunk of the ripple; the top-chunk carry out is always 0.
  assign csum = {1'b0, a_q[base +: CHUNK]}
              + {1'b0, b_q[base +: CHUNK]}
              + {{CHUNK{1'b0}}, c_q};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    r_d       = r_q;
    k_d       = k_q;
    c_d       = c_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          a_d     = {{(P-WIDTH){1'b0}}, in_sum};
          b_d     = {{(P-WIDTH-1){1'b0}}, in_carry};
          k_d     = '0;
          c_d     = 1'b0;
          state_d = ADD;
        end
      end
      ADD: begin
        for (int i = 0; i < WIDTH + 2; i++) begin
          if (i / CHUNK == int'(k_q))
            r_d[i] = csum[i % CHUNK];
        end
        c_d = csum[CHUNK];
        k_d = k_q + KW'(1);
        if (k_q == KW'(NCHUNK - 1))
          state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      k_q     <= k_d;
      c_q     <= c_d;
    end
  end

  assign out_result = r_q;

endmodule

// File: tb/tb_csa_final_adder.sv
// Bench for csa_final_adder: vector table, scoreboard queue, and
// hand-written backpressure, back-to-back and reset sequences.
module tb_csa_final_adder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] in_sum;
  logic [50:0] in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [51:0] out_result;
  logic        busy;

  int nvec = 0;
  int nerr = 0;
  logic [51:0] expq[$];

  typedef struct {
    logic [49:0] s;
    logic [50:0] c;
    logic [51:0] r;
  } vec_t;

  vec_t vt[8];

  csa_final_adder #(.WIDTH(50), .CHUNK(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every hand-off is checked against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_out: got %0h with no pending pair",
                 out_result);
      end else begin
        chk("result", {12'd0, out_result}, {12'd0, expq.pop_front()});
      end
    end
  end

  task automatic send(input logic [49:0] s, input logic [50:0] c,
                      input logic [51:0] e, input bit lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    in_sum   = s;
    in_carry = c;
    in_valid = 1'b1;
    expq.push_back(e);
    step();
    in_valid = 1'b0;
    in_sum   = 50'h2_5A5A_5A5A_5A5A;
    in_carry = 51'h7_0F0F_0F0F_0F0F;
    if (lat) chk("busy_in_add", 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (lat) chk("latency", 64'(n), 64'd6);
    else if (!out_valid) chk("valid_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expq.size() != 0 && n < 40) begin
      step();
      n++;
    end
    if (expq.size() != 0) begin
      chk("drain_timeout", 64'(expq.size()), 64'd0);
      expq.delete();
    end
  endtask

  initial begin
    logic [63:0] rs, rc;
    int acc;

    vt[0] = '{50'h3, 51'h4, 52'h7};
    vt[1] = '{50'h3_FFFF_FFFF_FFFF, 51'h2, 52'h4_0000_0000_0001};
    vt[2] = '{50'h3_FFFF_FFFF_FFFF, 51'h7_FFFF_FFFF_FFFE,
              52'hB_FFFF_FFFF_FFFD};
    vt[3] = '{50'h0, 51'h0, 52'h0};
    vt[4] = '{50'h0, 51'h4_0000_0000_0000, 52'h4_0000_0000_0000};
    vt[5] = '{50'h3FF, 51'h1, 52'h400};
    vt[6] = '{50'h2_AAAA_AAAA_AAAA, 51'h5_5555_5555_5555,
              52'h7_FFFF_FFFF_FFFF};
    vt[7] = '{50'h1_2345_6789_ABCD, 51'h0_1111_1111_1111,
              52'h1_3456_789A_BCDE};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_carry  = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_result", 64'(out_result), 64'd0);
    step();
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      send(vt[i].s, vt[i].c, vt[i].r, 1'b1);
      drain();
    end

    for (int i = 0; i < 6; i++) begin
      rs = {$urandom(), $urandom()};
      rc = {$urandom(), $urandom()};
      send(rs[49:0], rc[50:0], 52'(rs[49:0]) + 52'(rc[50:0]), 1'b0);
      drain();
    end

    out_ready = 1'b0;
    send(vt[7].s, vt[7].c, vt[7].r, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_sum   = 50'(i + 17);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_hold", 64'(out_result), 64'(vt[7].r));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("handoff_valid", 64'(out_valid), 64'd0);
    chk("handoff_in_ready", 64'(in_ready), 64'd1);
    chk("bp_queue", 64'(expq.size()), 64'd0);

    acc = 0;
    for (int i = 0; i < 40; i++) begin
      rs       = {$urandom(), $urandom()};
      rc       = {$urandom(), $urandom()};
      in_sum   = rs[49:0];
      in_carry = rc[50:0];
      in_valid = 1'b1;
      if (in_ready) begin
        expq.push_back(52'(rs[49:0]) + 52'(rc[50:0]));
        acc++;
      end
      step();
    end
    in_valid = 1'b0;
    drain();
    chk("b2b_count", 64'(acc), 64'd5);

    in_sum   = 50'h1_0000_0000_0123;
    in_carry = 51'h0_0000_0000_0456;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_result", 64'(out_result), 64'd0);
    step();
    rst = 1'b0;
    step();
    send(50'h1, 51'h0, 52'h1, 1'b1);
    drain();

    repeat (10) step();
    chk("leftover", 64'(expq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
